// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the general-register field decoder and
//               the register-instruction encoder: operand bit-width codes,
//               register-code anchors and the encoder state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Operand-size codes as used by the code segment and by requests
    localparam logic [1:0] BIT_WIDTH_16 = 2'b01;
    localparam logic [1:0] BIT_WIDTH_32 = 2'b10;

    // Register field codes at the two ends of the one-hot ordering
    // (one-hot MSB is code 000, one-hot LSB is code 111)
    localparam logic [2:0] REG_CODE_EAX = 3'b000;
    localparam logic [2:0] REG_CODE_EDI = 3'b111;

    // Encoder byte-sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        OPCODE = 2'd2,
        MODRM  = 2'd3
    } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/encode_register_instruction_if.sv
`default_nettype none
// ============================================================================
// Module      : encode_register_instruction_if
// Description : Request and byte-stream bundle of the register-instruction
//               encoder.
//               master : request producer / byte consumer
//               slave  : the encoder
//               req_*  : valid/ready request with opcode, width and registers
//               out_*  : valid/ready byte stream with last-byte marker
//               req_error : one-cycle pulse for a dropped illegal request
// Revision    : 1.0 - initial release
// ============================================================================
interface encode_register_instruction_if;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_opcode;
    logic [1:0] req_bit_width;
    logic       req_w_in_instruction;
    logic       req_w;
    logic       req_reg_in_opcode;
    logic [7:0] req_reg_dst;
    logic [7:0] req_reg_src;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic       req_error;

    modport master (
        output req_valid, req_opcode, req_bit_width, req_w_in_instruction,
               req_w, req_reg_in_opcode, req_reg_dst, req_reg_src, out_ready,
        input  req_ready, out_valid, out_byte, out_last, req_error
    );

    modport slave (
        input  req_valid, req_opcode, req_bit_width, req_w_in_instruction,
               req_w, req_reg_in_opcode, req_reg_dst, req_reg_src, out_ready,
        output req_ready, out_valid, out_byte, out_last, req_error
    );

endinterface
`default_nettype wire

// File: rtl/onehot_to_register_code.sv
`default_nettype none
// ============================================================================
// Module      : onehot_to_register_code
// Description : Converts an 8-bit one-hot register selection to its 3-bit
//               register code (MSB -> 000, LSB -> 111).
//               onehot    : one-hot register selection
//               code      : register code (meaningful only when onehot_ok)
//               onehot_ok : exactly one bit of onehot is set
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_register_code
    import decode_pkg::*;
(
    input  wire  [7:0] onehot,
    output logic [2:0] code,
    output logic       onehot_ok
);

    always_comb begin
        code = REG_CODE_EAX;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                code = REG_CODE_EDI - 3'(i);
            end
        end
    end

    // Non-zero and a power of two
    assign onehot_ok = (onehot != 8'h00) && ((onehot & (onehot - 8'h01)) == 8'h00);

endmodule
`default_nettype wire

// File: rtl/encode_register_instruction.sv
`default_nettype none
// ============================================================================
// Module      : encode_register_instruction
// Description : Encodes a one-hot register-to-register request into an IA-32
//               byte stream: optional operand-size prefix, opcode with the
//               w bit merged, and a mod=11 ModR/M byte (or a short form with
//               the register in opcode[2:0]). Bytes leave one per handshake.
//               clock   : rising-edge clock
//               reset_n : asynchronous active-low reset
//               bus     : request / byte-stream bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module encode_register_instruction
    import decode_pkg::*;
#(
    parameter logic [1:0] DEFAULT_BIT_WIDTH   = BIT_WIDTH_32,
    parameter logic [7:0] OPERAND_SIZE_PREFIX = 8'h66
) (
    input  wire clock,
    input  wire reset_n,
    encode_register_instruction_if.slave bus
);

    enc_state_t state;
    enc_state_t w_next_state;

    // Captured request fields
    logic [7:0] r_opcode;
    logic       r_w_in;
    logic       r_w;
    logic       r_short;
    logic [2:0] r_dst_code;
    logic [2:0] r_src_code;

    // Holds req_ready low until the first edge after reset release
    logic       r_started;

    logic       r_out_valid;
    logic [7:0] r_out_byte;
    logic       r_out_last;
    logic       r_error;

    logic [2:0] w_dst_code;
    logic [2:0] w_src_code;
    logic       w_dst_ok;
    logic       w_src_ok;
    logic       w_width_ok;
    logic       w_req_ok;
    logic       w_accept;
    logic       w_need_prefix;

    logic [7:0] w_sel_opcode;
    logic       w_sel_w_in;
    logic       w_sel_w;
    logic       w_sel_short;
    logic [2:0] w_sel_dst;
    logic [2:0] w_sel_src;
    logic [7:0] w_next_byte;
    logic       w_next_last;

    onehot_to_register_code u_dst_code (
        .onehot    (bus.req_reg_dst),
        .code      (w_dst_code),
        .onehot_ok (w_dst_ok)
    );

    onehot_to_register_code u_src_code (
        .onehot    (bus.req_reg_src),
        .code      (w_src_code),
        .onehot_ok (w_src_ok)
    );

    assign bus.req_ready = r_started && (state == IDLE);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_width_ok    = (bus.req_bit_width == BIT_WIDTH_16) ||
                           (bus.req_bit_width == BIT_WIDTH_32);
    // The short form has no ModR/M, so its source field is irrelevant
    assign w_req_ok      = w_dst_ok && (bus.req_reg_in_opcode || w_src_ok) && w_width_ok;
    // Byte operations (w_in=1, w=0) never take the operand-size prefix
    assign w_need_prefix = (bus.req_bit_width != DEFAULT_BIT_WIDTH) &&
                           (!bus.req_w_in_instruction || bus.req_w);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= w_next_state;
        end
    end

    // Next-state logic; every non-IDLE state is presenting a valid byte
    always_comb begin
        w_next_state = state;
        case (state)
            IDLE: begin
                if (w_accept && w_req_ok) begin
                    w_next_state = w_need_prefix ? PREFIX : OPCODE;
                end
            end
            PREFIX: begin
                if (bus.out_ready) w_next_state = OPCODE;
            end
            OPCODE: begin
                if (bus.out_ready) w_next_state = r_short ? IDLE : MODRM;
            end
            MODRM: begin
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic: computes the byte for the state being entered so that the
    // stream outputs can be registered. Leaving IDLE uses the live request
    // because the capture registers load on the same edge.
    always_comb begin
        w_sel_opcode = (state == IDLE) ? bus.req_opcode           : r_opcode;
        w_sel_w_in   = (state == IDLE) ? bus.req_w_in_instruction : r_w_in;
        w_sel_w      = (state == IDLE) ? bus.req_w                : r_w;
        w_sel_short  = (state == IDLE) ? bus.req_reg_in_opcode    : r_short;
        w_sel_dst    = (state == IDLE) ? w_dst_code               : r_dst_code;
        w_sel_src    = (state == IDLE) ? w_src_code               : r_src_code;
        w_next_byte  = 8'h00;
        w_next_last  = 1'b0;
        case (w_next_state)
            PREFIX: begin
                w_next_byte = OPERAND_SIZE_PREFIX;
            end
            OPCODE: begin
                if (w_sel_short) begin
                    w_next_byte = {w_sel_opcode[7:3], w_sel_dst};
                    w_next_last = 1'b1;
                end else begin
                    w_next_byte = {w_sel_opcode[7:1],
                                   w_sel_w_in ? w_sel_w : w_sel_opcode[0]};
                end
            end
            MODRM: begin
                w_next_byte = {2'b11, w_sel_src, w_sel_dst};
                w_next_last = 1'b1;
            end
            default: begin
                w_next_byte = 8'h00;
                w_next_last = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_started   <= 1'b0;
            r_opcode    <= 8'h00;
            r_w_in      <= 1'b0;
            r_w         <= 1'b0;
            r_short     <= 1'b0;
            r_dst_code  <= 3'b000;
            r_src_code  <= 3'b000;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_out_last  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_started   <= 1'b1;
            r_out_valid <= (w_next_state != IDLE);
            r_out_byte  <= w_next_byte;
            r_out_last  <= w_next_last;
            r_error     <= w_accept && !w_req_ok;
            if (w_accept && w_req_ok) begin
                r_opcode   <= bus.req_opcode;
                r_w_in     <= bus.req_w_in_instruction;
                r_w        <= bus.req_w;
                r_short    <= bus.req_reg_in_opcode;
                r_dst_code <= w_dst_code;
                r_src_code <= w_src_code;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_byte  = r_out_byte;
    assign bus.out_last  = r_out_last;
    assign bus.req_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_encode_register_instruction.sv
`default_nettype none
// ============================================================================
// Module      : tb_encode_register_instruction
// Description : Self-checking bench for encode_register_instruction using a
//               table of requests with hand-computed byte streams, plus
//               sequences for backpressure and mid-instruction reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encode_register_instruction;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    encode_register_instruction_if bus ();

    encode_register_instruction #(
        .DEFAULT_BIT_WIDTH   (2'b10),
        .OPERAND_SIZE_PREFIX (8'h66)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [7:0]  opcode;
        logic [1:0]  width;
        logic        w_in;
        logic        w;
        logic        short_form;
        logic [7:0]  dst;
        logic [7:0]  src;
        logic        err;
        int          n;
        logic [23:0] bytes;   // first byte in [23:16]
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(string name, logic [7:0] opcode, logic [1:0] width,
                                logic w_in, logic w, logic short_form,
                                logic [7:0] dst, logic [7:0] src, logic err,
                                int n, logic [23:0] bytes);
        vec_t v;
        v.name = name; v.opcode = opcode; v.width = width; v.w_in = w_in;
        v.w = w; v.short_form = short_form; v.dst = dst; v.src = src;
        v.err = err; v.n = n; v.bytes = bytes;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(vec_t v);
        bus.req_opcode           = v.opcode;
        bus.req_bit_width        = v.width;
        bus.req_w_in_instruction = v.w_in;
        bus.req_w                = v.w;
        bus.req_reg_in_opcode    = v.short_form;
        bus.req_reg_dst          = v.dst;
        bus.req_reg_src          = v.src;
    endtask

    // Called at posedge+1 with the encoder idle. Request accepted on the next
    // edge; its bytes must appear one per cycle starting the cycle after.
    task automatic run_vector(vec_t v);
        logic [7:0] eb;
        drive(v);
        bus.req_valid = 1'b1;
        check({v.name, " req_ready before accept"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        if (v.err) begin
            check({v.name, " req_error pulse"}, 32'(bus.req_error), 32'd1);
            check({v.name, " no out_valid"}, 32'(bus.out_valid), 32'd0);
            check({v.name, " req_ready stays"}, 32'(bus.req_ready), 32'd1);
            tick();
            check({v.name, " req_error cleared"}, 32'(bus.req_error), 32'd0);
            check({v.name, " still no out_valid"}, 32'(bus.out_valid), 32'd0);
        end else begin
            for (int k = 0; k < v.n; k++) begin
                eb = v.bytes[23 - 8*k -: 8];
                check($sformatf("%s byte%0d valid", v.name, k), 32'(bus.out_valid), 32'd1);
                check($sformatf("%s byte%0d value", v.name, k), 32'(bus.out_byte), 32'(eb));
                check($sformatf("%s byte%0d last", v.name, k), 32'(bus.out_last),
                      32'((k == v.n - 1) ? 1 : 0));
                check($sformatf("%s byte%0d no error", v.name, k), 32'(bus.req_error), 32'd0);
                tick();
            end
            check({v.name, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
            check({v.name, " idle req_ready"}, 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //          name        op     wid    win w  sf  dst    src    err n  bytes
        vecs[0]  = mk("t1_w32",  8'h00, 2'b10, 1, 1, 0, 8'h80, 8'h40, 0, 2, 24'h01C800);
        vecs[1]  = mk("t2_w16",  8'h00, 2'b01, 1, 1, 0, 8'h80, 8'h40, 0, 3, 24'h6601C8);
        vecs[2]  = mk("t3_byte", 8'h00, 2'b01, 1, 0, 0, 8'h08, 8'h10, 0, 2, 24'h00DC00);
        vecs[3]  = mk("t4_sf32", 8'h50, 2'b10, 0, 0, 1, 8'h01, 8'h00, 0, 1, 24'h570000);
        vecs[4]  = mk("t4_sf16", 8'h50, 2'b01, 0, 0, 1, 8'h01, 8'h00, 0, 2, 24'h665700);
        vecs[5]  = mk("e_dst03", 8'h00, 2'b10, 1, 1, 0, 8'h03, 8'h40, 1, 0, 24'h000000);
        vecs[6]  = mk("e_wid11", 8'h00, 2'b11, 1, 1, 0, 8'h80, 8'h40, 1, 0, 24'h000000);
        vecs[7]  = mk("e_src00", 8'h00, 2'b10, 1, 1, 0, 8'h80, 8'h00, 1, 0, 24'h000000);
        vecs[8]  = mk("nowin16", 8'h89, 2'b01, 0, 0, 0, 8'h20, 8'h02, 0, 3, 24'h6689F2);
        vecs[9]  = mk("wmerge",  8'h8A, 2'b10, 1, 1, 0, 8'h04, 8'h80, 0, 2, 24'h8BC500);
        vecs[10] = mk("sf_low",  8'h57, 2'b10, 0, 0, 1, 8'h80, 8'h00, 0, 1, 24'h500000);

        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(vecs[0]);

        // Reset state
        repeat (3) tick();
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_byte",  32'(bus.out_byte),  32'd0);
        check("reset out_last",  32'(bus.out_last),  32'd0);
        check("reset req_error", 32'(bus.req_error), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("release req_ready before edge", 32'(bus.req_ready), 32'd0);
        tick();
        check("first cycle req_ready", 32'(bus.req_ready), 32'd1);

        // Table-driven vectors, issued back to back
        for (int i = 0; i < 11; i++) begin
            run_vector(vecs[i]);
        end

        // Backpressure on byte 2 of the 16-bit request
        drive(vecs[1]);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("bp prefix", 32'(bus.out_byte), 32'h66);
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bp hold%0d valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp hold%0d byte", c),  32'(bus.out_byte),  32'h01);
            check($sformatf("bp hold%0d last", c),  32'(bus.out_last),  32'd0);
            check($sformatf("bp hold%0d req_ready", c), 32'(bus.req_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp modrm byte", 32'(bus.out_byte), 32'hC8);
        check("bp modrm last", 32'(bus.out_last), 32'd1);
        tick();
        check("bp idle", 32'(bus.out_valid), 32'd0);
        // Back-to-back request right after the single IDLE cycle
        run_vector(vecs[3]);

        // Reset during MODRM truncates the stream asynchronously
        drive(vecs[0]);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("rst opcode byte", 32'(bus.out_byte), 32'h01);
        tick();
        check("rst modrm byte", 32'(bus.out_byte), 32'hC8);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst out_valid async", 32'(bus.out_valid), 32'd0);
        check("rst req_ready async", 32'(bus.req_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("post-rst req_ready", 32'(bus.req_ready), 32'd1);
        check("post-rst out_valid", 32'(bus.out_valid), 32'd0);
        run_vector(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
